// File: rtl/mean_pkg.sv
// Shared types and helpers for the round-robin block-mean scheduler.
package mean_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index that follows idx in a ring of ch entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned ch);
        return (idx + 32'd1 >= ch) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned CH   = 4,
    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic [CH-1:0]   i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic            o_any,
    output logic [CH_W-1:0] o_idx
);

    logic [CH_W-1:0] w_cand;

    // Scan ptr, ptr+1, ... mod CH and keep the first requester found.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_cand = CH_W'((32'(i_ptr) + i) % CH);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/mean_rr_sched.sv
// Round-robin scheduler sharing one 2^N-sample block averager among CH sources.
module mean_rr_sched
    import mean_pkg::*;
#(
    parameter  int unsigned WIDTH       = 32,
    parameter  int unsigned N           = 2,
    parameter  int unsigned DEPTH_WIDTH = 34,
    parameter  int unsigned CH          = 4,
    localparam int unsigned CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CH-1:0]       i_vld,
    input  logic [CH*WIDTH-1:0] i_data,
    output logic [CH-1:0]       o_rdy,
    input  logic                i_flush,
    output logic                o_vld,
    output logic [WIDTH-1:0]    o_data,
    output logic [CH_W-1:0]     o_ch,
    input  logic                i_rdy,
    output logic                o_busy
);

    localparam int unsigned CNT_W = (N > 0) ? N : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << N) - 1);

    if (DEPTH_WIDTH < WIDTH + N) begin : g_bad_depth
        $fatal(1, "mean_rr_sched: DEPTH_WIDTH must be >= WIDTH+N");
    end

    state_t                 r_state;
    state_t                 w_next;
    logic [CH_W-1:0]        r_grant;
    logic [CH_W-1:0]        r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [DEPTH_WIDTH-1:0] r_sum;
    logic                   r_vld;
    logic [WIDTH-1:0]       r_data;
    logic [CH_W-1:0]        r_ch;

    logic                   w_any;
    logic [CH_W-1:0]        w_idx;
    logic [WIDTH-1:0]       w_sel;
    logic                   w_beat;
    logic                   w_last;
    logic [DEPTH_WIDTH-1:0] w_acc;
    logic [DEPTH_WIDTH-1:0] w_mean;

    rr_arbiter #(.CH(CH)) u_arb (
        .i_req (i_vld),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Granted channel's sample and the running sum including it.
    always_comb begin
        w_sel  = i_data[r_grant*WIDTH +: WIDTH];
        w_beat = i_vld[r_grant] & o_rdy[r_grant];
        w_last = (r_cnt == LAST);
        w_acc  = ((r_cnt == '0) ? '0 : r_sum) + DEPTH_WIDTH'(w_sel);
        w_mean = w_acc >> N;
    end

    // Ready only to the granted channel while accumulating; a flush blocks the beat.
    always_comb begin
        o_rdy = '0;
        if (r_state == ACCUM && !i_flush) begin
            o_rdy[r_grant] = 1'b1;
        end
    end

    // Next-state decode; flush returns to IDLE from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ACCUM;
            ACCUM:   if (w_beat && w_last) w_next = DONE;
            DONE:    if (i_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (i_flush) begin
            w_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, beat counter, accumulator and held result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_vld   <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_idx;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_sum <= w_acc;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_data <= w_mean[WIDTH-1:0];
                            r_ch   <= r_grant;
                            r_vld  <= 1'b1;
                            r_ptr  <= CH_W'(rr_next(32'(r_grant), CH));
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        r_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_ch   = r_ch;
    assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_mean_rr_sched.sv
// Bench for mean_rr_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_mean_rr_sched;

    localparam int CH  = 4;
    localparam int W   = 32;
    localparam int BLK = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [CH-1:0]    i_vld;
    logic [CH*W-1:0]  i_data;
    logic [CH-1:0]    o_rdy;
    logic             i_flush;
    logic             o_vld;
    logic [W-1:0]     o_data;
    logic [1:0]       o_ch;
    logic             i_rdy;
    logic             o_busy;

    mean_rr_sched #(.WIDTH(32), .N(2), .DEPTH_WIDTH(34), .CH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_vld   (i_vld),
        .i_data  (i_data),
        .o_rdy   (o_rdy),
        .i_flush (i_flush),
        .o_vld   (o_vld),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .i_rdy   (i_rdy),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int vcyc = 0;

    logic [31:0] q [4][$];
    bit          gate [4];
    logic [39:0] rlog [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which channel holds the averager, samples collected so far, pending result.
    int          m_phase;   // 0 waiting, 1 collecting, 2 result held
    int unsigned m_grant, m_ptr;
    int          m_n;
    longint unsigned m_acc;
    bit          m_vld;
    logic [31:0] m_data;
    int unsigned m_ch;

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = 0; m_grant = 0; m_ptr = 0; m_n = 0; m_acc = 0;
            m_vld = 0; m_data = 0; m_ch = 0;
        end else if (i_flush) begin
            m_phase = 0; m_n = 0; m_acc = 0; m_vld = 0;
        end else if (m_phase == 0) begin
            for (int i = 0; i < CH; i++) begin
                int unsigned j;
                j = (m_ptr + i) % CH;
                if (i_vld[j]) begin
                    m_grant = j;
                    m_phase = 1;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            if (i_vld[m_grant]) begin
                m_acc += i_data[m_grant*W +: W];
                m_n++;
                if (m_n == BLK) begin
                    m_data  = 32'(m_acc / BLK);
                    m_ch    = m_grant;
                    m_vld   = 1;
                    m_ptr   = (m_grant + 1) % CH;
                    m_n     = 0;
                    m_acc   = 0;
                    m_phase = 2;
                end
            end
        end else if (i_rdy) begin
            m_vld   = 0;
            m_phase = 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_vld",  o_vld,  m_vld);
            chk("o_data", o_data, m_data);
            chk("o_ch",   o_ch,   m_ch);
            chk("o_rdy",  o_rdy,  (m_phase == 1 && !i_flush) ? (64'd1 << m_grant) : 64'd0);
            chk("o_busy", o_busy, m_phase != 0);
            if (o_vld === 1'b1) vcyc++;
        end
    end

    // Log of results the DUT handed downstream.
    always @(posedge clk) begin
        if (rstn && !i_flush && o_vld === 1'b1 && i_rdy) begin
            rlog.push_back({8'(o_ch), o_data});
        end
    end

    task automatic refresh();
        for (int k = 0; k < CH; k++) begin
            i_vld[k] = !gate[k] && (q[k].size() > 0);
            i_data[k*W +: W] = (q[k].size() > 0) ? q[k][0] : 32'h0;
        end
    endtask

    task automatic step();
        logic [CH-1:0] f;
        @(negedge clk);
        f = o_rdy & i_vld;
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            if (f[k] === 1'b1 && q[k].size() > 0) void'(q[k].pop_front());
        end
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_flush = 1'b0;
        for (int k = 0; k < CH; k++) begin
            q[k].delete();
            gate[k] = 1'b0;
        end
        refresh();
        step();
        step();
        rstn = 1'b1;
        rlog.delete();
        vcyc = 0;
    endtask

    task automatic chk_res(input int idx, input int ch, input logic [31:0] data);
        if (idx >= rlog.size()) begin
            chk("res_present", rlog.size(), idx + 1);
        end else begin
            chk("res_ch_data", rlog[idx], {8'(ch), data});
        end
    endtask

    task automatic fill(input int k, input int cnt, input logic [31:0] v);
        repeat (cnt) q[k].push_back(v);
    endtask

    initial begin
        rstn = 1'b0; i_flush = 1'b0; i_rdy = 1'b1; i_vld = '0; i_data = '0;
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_o_vld",  o_vld,  0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_ch",   o_ch,   0);
        chk("rst_o_rdy",  o_rdy,  0);
        chk("rst_o_busy", o_busy, 0);

        // Single channel, samples 1..4 -> mean 2.
        q[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
        refresh();
        run(8);
        chk("t1_count", rlog.size(), 1);
        chk_res(0, 0, 32'd2);
        chk("t1_vld_cycles", vcyc, 1);
        chk("t1_busy_after", o_busy, 0);

        // All channels busy: fair rotation 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < CH; k++) fill(k, 8, 32'(10 * k + 10));
        i_rdy = 1'b1;
        refresh();
        run(32);
        chk_res(0, 0, 32'd10);
        chk_res(1, 1, 32'd20);
        chk_res(2, 2, 32'd30);
        chk_res(3, 3, 32'd40);
        chk_res(4, 0, 32'd10);

        // ch2 with bubbles while ch1 waits.
        do_reset();
        q[2] = '{32'd5, 32'd6, 32'd7, 32'd8};
        fill(1, 4, 32'd50);
        gate[1] = 1'b1;
        refresh();
        step();
        gate[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            gate[2] = !(c == 0 || c == 3 || c == 4 || c == 9);
            refresh();
            step();
            chk("t3_rdy1_low", o_rdy[1], 0);
        end
        gate[2] = 1'b0;
        run(10);
        chk_res(0, 2, 32'd6);
        chk_res(1, 1, 32'd50);

        // Result held while downstream stalls.
        do_reset();
        i_rdy = 1'b0;
        q[3] = '{32'd7, 32'd7, 32'd7, 32'd9};
        refresh();
        run(5);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t4_vld",  o_vld,  1);
            chk("t4_data", o_data, 32'd7);
            chk("t4_ch",   o_ch,   3);
            chk("t4_rdy",  o_rdy,  0);
        end
        i_rdy = 1'b1;
        step();
        chk("t4_vld_after",  o_vld,  0);
        chk("t4_busy_after", o_busy, 0);
        chk_res(0, 3, 32'd7);

        // Max values, then a block proving the sum restarts.
        do_reset();
        fill(3, 4, 32'hFFFF_FFFF);
        q[3].push_back(32'd0); q[3].push_back(32'd0);
        q[3].push_back(32'd0); q[3].push_back(32'd1);
        refresh();
        run(14);
        chk_res(0, 3, 32'hFFFF_FFFF);
        chk_res(1, 3, 32'd0);

        // Flush mid-block, partial sum discarded.
        do_reset();
        q[1] = '{32'd100, 32'd100};
        refresh();
        run(3);
        fill(1, 4, 32'd4);
        i_flush = 1'b1;
        refresh();
        step();
        i_flush = 1'b0;
        refresh();
        run(10);
        chk("t6_count", rlog.size(), 1);
        chk_res(0, 1, 32'd4);

        // Reset while result pending: nothing emitted, pointer back to 0.
        do_reset();
        i_rdy = 1'b0;
        fill(1, 4, 32'd4);
        refresh();
        run(5);
        chk("t7_pending", o_vld, 1);
        rstn = 1'b0;
        step();
        chk("t7_vld_rst",  o_vld,  0);
        chk("t7_busy_rst", o_busy, 0);
        chk("t7_data_rst", o_data, 0);
        rstn = 1'b1;
        chk("t7_no_result", rlog.size(), 0);
        fill(1, 4, 32'd1);
        fill(3, 4, 32'd3);
        i_rdy = 1'b1;
        refresh();
        step();
        chk("t7_grant_ptr0", o_rdy, 4'b0010);
        run(12);
        chk_res(0, 1, 32'd1);
        chk_res(1, 3, 32'd3);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < CH; k++) begin
                if (q[k].size() < 2 && $urandom_range(0, 3) == 0) begin
                    for (int m = 0; m < 3; m++)
                        q[k].push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
                end
                gate[k] = ($urandom_range(0, 3) == 0);
            end
            i_rdy   = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 39) == 0);
            rstn    = ($urandom_range(0, 149) != 0);
            refresh();
            step();
        end
        rstn = 1'b1;
        i_flush = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
